// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  // Smallest divisor that still yields a well-formed square wave.
  localparam int MIN_DIV = 2;

  // Channel-index width; a single channel still gets a one-bit index.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: free-running counter, active/shadow divisor pair and
// registered square-wave / tick outputs. Divisor changes land only on a wrap,
// a sync or while disabled, so a running period is never cut short.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W   = 28,
  parameter int DEF_DIV = 100000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_div,
  output logic             o_clk,
  output logic             o_tick
);

  localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE_V     = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_div_act;
  logic [CNT_W-1:0] r_div_shd;
  logic             r_pend;
  logic             r_clk;
  logic             r_tick;

  logic [CNT_W-1:0] w_last;
  logic [CNT_W-1:0] w_half;
  logic [CNT_W-1:0] w_new_div;
  logic             w_wrap;
  logic             w_apply;
  logic             w_have_upd;

  assign w_last = r_div_act - ONE_V;
  assign w_half = r_div_act >> 1;

  // >= rather than == so a counter that somehow overshoots still recovers.
  assign w_wrap = (r_count >= w_last);

  // Points where a new divisor may take over without creating a runt phase.
  assign w_apply = i_sync || !i_en || w_wrap;

  // A write in the same cycle as an apply point supersedes the older shadow.
  assign w_have_upd = i_wr || r_pend;
  assign w_new_div  = i_wr ? i_wr_div : r_div_shd;

  // Period counter: held at 0 when disabled, restarted by sync, wraps at D-1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (!i_en || i_sync || w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + ONE_V;
    end
  end

  // Shadow capture and deferred transfer into the active divisor.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_act <= DEF_DIV_V;
      r_div_shd <= DEF_DIV_V;
      r_pend    <= 1'b0;
    end else begin
      if (i_wr) begin
        r_div_shd <= i_wr_div;
      end
      if (w_apply) begin
        if (w_have_upd) begin
          r_div_act <= w_new_div;
        end
        r_pend <= 1'b0;
      end else if (i_wr) begin
        r_pend <= 1'b1;
      end
    end
  end

  // Outputs registered from the current count: high for floor(D/2), tick on D-1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_clk  <= i_en && (r_count < w_half);
      r_tick <= i_en && (r_count == w_last);
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;

endmodule

// File: rtl/clock_divider_mc.sv
// Multi-channel programmable clock divider: config decode and range check,
// write-reject pulse, and fan-out of sync/enable to the per-channel dividers.
module clock_divider_mc
  import clkdiv_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int CNT_W    = 28,
  parameter  int DEF_DIV  = 100000,
  localparam int CH_W     = ch_width(CHANNELS)
) (
  input  logic                clk_i,
  input  logic                reset,
  input  logic [CHANNELS-1:0] en_i,
  input  logic                sync_i,
  input  logic                cfg_we_i,
  input  logic [CH_W-1:0]     cfg_ch_i,
  input  logic [CNT_W-1:0]    cfg_div_i,
  output logic                cfg_err_o,
  output logic [CHANNELS-1:0] clk_o,
  output logic [CHANNELS-1:0] tick_o
);

  localparam int              CH_W1    = CH_W + 1;
  localparam logic [CH_W:0]   CH_LIM   = CH_W1'(CHANNELS);
  localparam logic [CNT_W-1:0] MIN_DIV_V = CNT_W'(MIN_DIV);

  logic                r_cfg_err;
  logic                w_ch_ok;
  logic                w_div_ok;
  logic                w_accept;
  logic [CHANNELS-1:0] w_wr;
  logic [CHANNELS-1:0] w_clk;
  logic [CHANNELS-1:0] w_tick;

  // Index compared one bit wider so a non-power-of-two channel count is caught.
  assign w_ch_ok  = ({1'b0, cfg_ch_i} < CH_LIM);
  assign w_div_ok = (cfg_div_i >= MIN_DIV_V);
  assign w_accept = cfg_we_i && w_ch_ok && w_div_ok;

  // One-cycle reject pulse following any out-of-range write.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we_i && !(w_ch_ok && w_div_ok);
    end
  end

  assign cfg_err_o = r_cfg_err;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign w_wr[g] = w_accept && (cfg_ch_i == CH_W'(g));

    clkdiv_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .i_clk    (clk_i),
      .i_rst_n  (reset),
      .i_en     (en_i[g]),
      .i_sync   (sync_i),
      .i_wr     (w_wr[g]),
      .i_wr_div (cfg_div_i),
      .o_clk    (w_clk[g]),
      .o_tick   (w_tick[g])
    );
  end

  assign clk_o  = w_clk;
  assign tick_o = w_tick;

endmodule

// File: tb/tb_clock_divider_mc.sv
// Directed bench for clock_divider_mc: 3 channels, 8-bit counters, DEF_DIV=10.
module tb_clock_divider_mc;

  localparam int CHANNELS = 3;
  localparam int CNT_W    = 8;
  localparam int DEF_DIV  = 10;
  localparam int CH_W     = 2;
  localparam int LIMIT    = 100;

  logic                clk_i;
  logic                reset;
  logic [CHANNELS-1:0] en_i;
  logic                sync_i;
  logic                cfg_we_i;
  logic [CH_W-1:0]     cfg_ch_i;
  logic [CNT_W-1:0]    cfg_div_i;
  logic                cfg_err_o;
  logic [CHANNELS-1:0] clk_o;
  logic [CHANNELS-1:0] tick_o;

  int n_chk;
  int n_bad;

  clock_divider_mc #(
    .CHANNELS (CHANNELS),
    .CNT_W    (CNT_W),
    .DEF_DIV  (DEF_DIV)
  ) dut (
    .clk_i     (clk_i),
    .reset     (reset),
    .en_i      (en_i),
    .sync_i    (sync_i),
    .cfg_we_i  (cfg_we_i),
    .cfg_ch_i  (cfg_ch_i),
    .cfg_div_i (cfg_div_i),
    .cfg_err_o (cfg_err_o),
    .clk_o     (clk_o),
    .tick_o    (tick_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Measure one full period of clk_o[ch] starting at the next rising edge.
  // Called at a negedge; returns at the negedge where the following period rises.
  task automatic meas(input int ch, output int hi, output int lo, output int tk_last);
    int guard;
    int tk_pos;
    int n_tk;
    hi = 0; lo = 0; tk_pos = -1; n_tk = 0; guard = 0;
    while (clk_o[ch] !== 1'b0 && guard < LIMIT) begin @(negedge clk_i); guard++; end
    while (clk_o[ch] !== 1'b1 && guard < LIMIT) begin @(negedge clk_i); guard++; end
    while (clk_o[ch] === 1'b1 && guard < LIMIT) begin
      if (tick_o[ch]) n_tk++;
      hi++;
      @(negedge clk_i); guard++;
    end
    while (clk_o[ch] === 1'b0 && guard < LIMIT) begin
      if (tick_o[ch]) begin n_tk++; tk_pos = lo; end
      lo++;
      @(negedge clk_i); guard++;
    end
    tk_last = (n_tk == 1 && tk_pos == lo - 1) ? 1 : 0;
    chk($sformatf("meas_bound_ch%0d", ch), (guard < LIMIT) ? 1 : 0, 1);
  endtask

  // Count consecutive samples of clk_o[ch] equal to val, starting with the current one.
  task automatic run_len(input int ch, input logic val, output int n);
    int guard;
    n = 0; guard = 0;
    while (clk_o[ch] === val && guard < LIMIT) begin
      n++;
      @(negedge clk_i); guard++;
    end
    chk($sformatf("run_bound_ch%0d", ch), (guard < LIMIT) ? 1 : 0, 1);
  endtask

  // One-cycle write strobe, driven from the current negedge.
  task automatic cfg_write(input int ch, input int div);
    cfg_we_i  = 1'b1;
    cfg_ch_i  = CH_W'(ch);
    cfg_div_i = CNT_W'(div);
    @(negedge clk_i);
    cfg_we_i  = 1'b0;
  endtask

  task automatic check_period(input string tag, input int ch, input int e_hi, input int e_lo);
    int hi, lo, tk;
    meas(ch, hi, lo, tk);
    chk({tag, "_hi"}, hi, e_hi);
    chk({tag, "_lo"}, lo, e_lo);
    chk({tag, "_tick"}, tk, 1);
  endtask

  initial begin
    int n;
    int cnt;
    n_chk = 0; n_bad = 0;
    reset = 1'b0; en_i = '0; sync_i = 1'b0;
    cfg_we_i = 1'b0; cfg_ch_i = '0; cfg_div_i = '0;

    repeat (3) @(negedge clk_i);
    chk("rst_clk", clk_o, 0);
    chk("rst_tick", tick_o, 0);
    chk("rst_err", cfg_err_o, 0);

    reset = 1'b1;
    en_i  = 3'b111;

    // Defaults: 5 high / 5 low on every channel.
    for (int c = 0; c < CHANNELS; c++) check_period($sformatf("def%0d", c), c, 5, 5);

    // Odd divisor on channel 1; channel 0 untouched.
    cfg_write(1, 5);
    check_period("odd1", 1, 2, 3);
    check_period("odd1_again", 1, 2, 3);
    check_period("keep0", 0, 5, 5);

    // Write 4 to channel 0 while its count is 3: old 10-cycle period completes.
    @(negedge clk_i);
    @(negedge clk_i);
    cfg_write(0, 4);
    run_len(0, 1'b1, n);
    chk("glitch_rest_hi", n, 2);
    run_len(0, 1'b0, n);
    chk("glitch_lo", n, 5);
    check_period("div4", 0, 2, 2);

    // Write 6 in channel 0's wrap cycle (count 3 of 4): next period is 6.
    @(negedge clk_i);
    @(negedge clk_i);
    cfg_write(0, 6);
    chk("wrap_tick", tick_o[0], 1);
    check_period("wrapwr", 0, 3, 3);

    // Rejected writes: one-cycle error pulse, no state change.
    cfg_write(0, 1);
    chk("rej_div1_err", cfg_err_o, 1);
    @(negedge clk_i);
    chk("rej_div1_clr", cfg_err_o, 0);
    cfg_write(0, 0);
    chk("rej_div0_err", cfg_err_o, 1);
    @(negedge clk_i);
    chk("rej_div0_clr", cfg_err_o, 0);
    cfg_write(3, 4);
    chk("rej_ch_err", cfg_err_o, 1);
    @(negedge clk_i);
    chk("rej_ch_clr", cfg_err_o, 0);
    check_period("rej_keep0", 0, 3, 3);
    check_period("rej_keep1", 1, 2, 3);

    // Repeated writes before a wrap: last one wins.
    check_period("pre2", 2, 5, 5);
    cfg_write(2, 9);
    chk("good_wr_noerr", cfg_err_o, 0);
    cfg_write(2, 8);
    check_period("last_wins2", 2, 4, 4);

    // Sync with channels at divisors 6/5/8 and mixed phases.
    repeat (3) @(negedge clk_i);
    sync_i = 1'b1;
    @(negedge clk_i);
    sync_i = 1'b0;
    @(negedge clk_i);
    chk("sync_rise", clk_o, 3'b111);
    @(negedge clk_i);
    chk("sync_s3", clk_o, 3'b111);
    en_i[2] = 1'b0;
    @(negedge clk_i);
    chk("sync_s4_dis", clk_o, 3'b001);
    chk("dis_tick", tick_o[2], 0);
    @(negedge clk_i);
    chk("sync_s5", clk_o, 3'b000);

    // Channel 2 stays quiet while disabled.
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (clk_o[2] || tick_o[2]) cnt++;
      @(negedge clk_i);
    end
    chk("dis_quiet", cnt, 0);

    // Re-enable: full high phase at divisor 8.
    en_i[2] = 1'b1;
    run_len(2, 1'b0, n);
    run_len(2, 1'b1, n);
    chk("reen_hi", n, 4);
    check_period("reen2", 2, 4, 4);

    // Reset mid-high-phase: outputs clear immediately, divisors back to default.
    meas(0, n, cnt, cnt);
    chk("pre_rst_high", clk_o[0], 1);
    reset = 1'b0;
    #1;
    chk("rst_async_clk", clk_o, 0);
    chk("rst_async_tick", tick_o, 0);
    @(negedge clk_i);
    reset = 1'b1;
    for (int c = 0; c < CHANNELS; c++) check_period($sformatf("post_rst%0d", c), c, 5, 5);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_divider_mc.md
# clock_divider_mc

Multi-channel, runtime-programmable clock divider for the clock subsystem. Each of CHANNELS independent channels divides `clk_i` by its own divisor and produces:

- a square-wave output, high for the first half of each period;
- a single-cycle tick, one per period.

Divisors can be reprogrammed glitch-free while running, and all channels can be phase-aligned on command. The block feeds the 1 kHz scan, 1 Hz timekeeping and blink-rate enables from one instance.

## Interface

Parameters:

- `CHANNELS`, 4, number of independent divider channels (≥1).
- `CNT_W`, 28, counter and divisor width.
- `DEF_DIV`, 100000, divisor loaded into every channel at reset (≥2).
- Local `CH_W` = max(1, $clog2(CHANNELS)).

Ports:

- `clk_i`, in, 1: the single system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `en_i`, in, CHANNELS: per-channel run enable.
- `sync_i`, in, 1: one-cycle strobe that restarts all channels at phase 0.
- `cfg_we_i`, in, 1: divisor write strobe.
- `cfg_ch_i`, in, CH_W: target channel index.
- `cfg_div_i`, in, CNT_W: new divisor.
- `cfg_err_o`, out, 1: one-cycle pulse when a write is rejected.
- `clk_o`, out, CHANNELS: per-channel divided square wave.
- `tick_o`, out, CHANNELS: per-channel one-cycle wrap pulse.

## Operation

- **Per-channel state:** `count` (CNT_W), `div_act` (active divisor), `div_shd` (shadow divisor), `pend` (update pending).
- **Reset (async, `reset`=0):**
  - `count`=0, `div_act`=`div_shd`=DEF_DIV, `pend`=0.
  - `clk_o`=0, `tick_o`=0, `cfg_err_o`=0.
  - Reset takes effect immediately, including mid-period.
- **Enabled channel:**
  - `count` increments each cycle.
  - When `count` ≥ `div_act`−1, `count` goes to 0 (wrap). The ≥ comparison is defensive.
  - At a wrap, if `pend`=1: `div_act`←`div_shd` and `pend`←0.
- **Disabled channel:** `count` is held at 0; `clk_o`=0 and `tick_o`=0 from the next cycle. A pending update is applied immediately.
- **Outputs (registered from the current `count`):**
  - `clk_o`←(en && `count` < `div_act`/2), integer division.
  - `tick_o`←(en && `count` == `div_act`−1).
  - Resulting waveform for divisor D: high for floor(D/2) cycles, low for ceil(D/2) cycles, period D. `tick_o` coincides with the last low cycle.
- **Config write** (`cfg_we_i`=1), accepted only if `cfg_ch_i` < CHANNELS and `cfg_div_i` ≥ 2:
  - Accepted: `div_shd`←`cfg_div_i`, `pend`←1. The current period always completes at the old divisor.
  - Rejected: `cfg_err_o`=1 for one cycle and no state changes.
- **Write in a channel's wrap cycle:** the new value is applied at that wrap; the next period uses the new divisor.
- **Repeated writes before a wrap:** the last accepted write wins.
- **`sync_i`=1:**
  - All channels set `count`←0.
  - Pending updates are applied, including a same-cycle accepted write, which is processed before sync.
  - All enabled channels' `clk_o` rise together.
- **`sync_i` with `en_i` low:** no effect beyond applying pending updates.

## Timing

- Output latency is one cycle from `count` to `clk_o`/`tick_o`.
- After `en_i` rises (or on `sync_i`), the channel's `clk_o` is high in the second cycle after the en/sync edge and stays high for floor(D/2) cycles.
- `cfg_err_o` is asserted in the cycle after the rejected strobe.
- There is no ready/valid handshake; a write is accepted every cycle.
- Divisor changes never produce a runt high or low phase on `clk_o`, except where `sync_i`, `en_i` deassertion or `reset` intentionally truncates a period.
- Maximum divisor is 2^CNT_W−1.

## Structure

- **Package `clkdiv_pkg`:** `MIN_DIV`=2, and a function computing CH_W.
- **Sub-module `clkdiv_channel`:** holds one channel's counter, active/shadow divisor and output registers, instantiated CHANNELS times in a generate loop.
- **Top level:** config decode, range check, `cfg_err_o`, and `sync_i` fan-out.

## Test plan

- **Defaults:** bench uses DEF_DIV=10, `en_i`=all 1 after reset. Every `clk_o` is 5 high / 5 low, and `tick_o` pulses every 10 cycles on the last low cycle.
- **Odd divisor:** write 5 to channel 1. After the current period, `clk_o[1]` is 2 high / 3 low, `tick_o[1]` period 5, and other channels are unchanged.
- **Glitch-free update:** write 4 to channel 0 when its `count`=3. The current 10-cycle period completes, then the period is 4 (2/2). Also write in a wrap cycle: the very next period uses the new value.
- **Rejects:** write divisor 1, divisor 0, and `cfg_ch_i`=CHANNELS (CHANNELS<2^CH_W). Each gives a one-cycle `cfg_err_o` and unchanged periods.
- **Sync/enable:** with channels at mixed phases, pulse `sync_i`; all enabled `clk_o` rise in the same cycle. Drop `en_i[2]`: `clk_o[2]`/`tick_o[2]` go 0 next cycle. Re-enable: a full high phase follows.
- **Reset mid-operation:** assert `reset` mid-high-phase after divisor writes. Outputs go 0 immediately, and after release all periods are back to DEF_DIV.
